io_interface: RTL and testbench

IO_INTERFACE -- requirements
Module: io_interface

---
 rtl/io_interface.sv | 118 +++++++++++
 tb/tb_io_interface.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/io_interface.sv
// Character I/O port: INPR/FGI input side, OUTR/FGO output side, optional IEN/INT_REQ (IO_INTERRUPT_EN).
// Latency: one CLK edge from accepted capture/OUT_EXEC to visible flag change; INT_REQ is one edge behind its terms.
// Backpressure: IN_READY drops while FGI holds a character; OUTR is held until the device takes it with OUT_READY.
module io_interface #(
  parameter int U = 8
) (
  input  logic         CLK,
  input  logic         CLR_N,
  input  logic [U-1:0] IN_DATA,
  input  logic         IN_VALID,
  output logic         IN_READY,
  output logic [U-1:0] INPR_DATA,
  output logic         FGI,
  input  logic         INP_EXEC,
  input  logic         OUT_EXEC,
  input  logic [U-1:0] AC_LOW,
  output logic [U-1:0] OUTR_DATA,
  output logic         OUT_VALID,
  input  logic         OUT_READY,
  output logic         FGO,
  input  logic         ION,
  input  logic         IOF,
  input  logic         INT_ACK,
  output logic         IEN,
  output logic         INT_REQ,
  output logic         ERR
);

  logic [U-1:0] inpr_q;
  logic         fgi_q;
  logic [U-1:0] outr_q;
  logic         out_vld_q;
  logic         err_q;

  logic in_take;
  logic inp_ok;
  logic inp_bad;
  logic out_ok;
  logic out_bad;
  logic out_taken;

  always_comb begin
    in_take   = IN_VALID & ~fgi_q;
    inp_ok    = INP_EXEC & fgi_q;
    inp_bad   = INP_EXEC & ~fgi_q;
    out_ok    = OUT_EXEC & ~out_vld_q;
    out_bad   = OUT_EXEC & out_vld_q;
    out_taken = out_vld_q & OUT_READY;
  end

  // Capture and INP consumption are mutually exclusive because capture needs FGI=0.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      inpr_q <= '0;
      fgi_q  <= 1'b0;
    end else if (in_take) begin
      inpr_q <= IN_DATA;
      fgi_q  <= 1'b1;
    end else if (inp_ok) begin
      fgi_q  <= 1'b0;
    end
  end

  // OUTR keeps the last character after the device takes it; only the flag drops.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      outr_q    <= '0;
      out_vld_q <= 1'b0;
    end else if (out_ok) begin
      outr_q    <= AC_LOW;
      out_vld_q <= 1'b1;
    end else if (out_taken) begin
      out_vld_q <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      err_q <= 1'b0;
    end else if (inp_bad | out_bad) begin
      err_q <= 1'b1;
    end
  end

`ifdef IO_INTERRUPT_EN
  logic ien_q;
  logic int_req_q;

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      ien_q     <= 1'b0;
      int_req_q <= 1'b0;
    end else begin
      if (INT_ACK)   ien_q <= 1'b0;
      else if (IOF)  ien_q <= 1'b0;
      else if (ION)  ien_q <= 1'b1;
      int_req_q <= ien_q & (fgi_q | ~out_vld_q) & ~INT_ACK;
    end
  end

  assign IEN     = ien_q;
  assign INT_REQ = int_req_q;
`else
  logic unused_int_inputs;
  assign unused_int_inputs = ION ^ IOF ^ INT_ACK;
  assign IEN     = 1'b0;
  assign INT_REQ = 1'b0;
`endif

  assign IN_READY  = ~fgi_q;
  assign INPR_DATA = inpr_q;
  assign FGI       = fgi_q;
  assign OUTR_DATA = outr_q;
  assign OUT_VALID = out_vld_q;
  assign FGO       = ~out_vld_q;
  assign ERR       = err_q;

endmodule

// File: tb/tb_io_interface.sv
// Directed bench for io_interface: input/output handshakes, protocol errors, async reset, interrupt enable.
module tb_io_interface;

  localparam int U = 8;

  logic         CLK;
  logic         CLR_N;
  logic [U-1:0] IN_DATA;
  logic         IN_VALID;
  logic         IN_READY;
  logic [U-1:0] INPR_DATA;
  logic         FGI;
  logic         INP_EXEC;
  logic         OUT_EXEC;
  logic [U-1:0] AC_LOW;
  logic [U-1:0] OUTR_DATA;
  logic         OUT_VALID;
  logic         OUT_READY;
  logic         FGO;
  logic         ION;
  logic         IOF;
  logic         INT_ACK;
  logic         IEN;
  logic         INT_REQ;
  logic         ERR;

  int tests_run = 0;
  int tests_failed = 0;

  io_interface #(.U(U)) dut (
    .CLK(CLK), .CLR_N(CLR_N),
    .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .INPR_DATA(INPR_DATA), .FGI(FGI), .INP_EXEC(INP_EXEC),
    .OUT_EXEC(OUT_EXEC), .AC_LOW(AC_LOW), .OUTR_DATA(OUTR_DATA),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .FGO(FGO),
    .ION(ION), .IOF(IOF), .INT_ACK(INT_ACK),
    .IEN(IEN), .INT_REQ(INT_REQ), .ERR(ERR)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".inpr"},     32'(INPR_DATA), 32'h00);
    chk({tag, ".fgi"},      32'(FGI),       32'd0);
    chk({tag, ".in_ready"}, 32'(IN_READY),  32'd1);
    chk({tag, ".outr"},     32'(OUTR_DATA), 32'h00);
    chk({tag, ".out_vld"},  32'(OUT_VALID), 32'd0);
    chk({tag, ".fgo"},      32'(FGO),       32'd1);
    chk({tag, ".ien"},      32'(IEN),       32'd0);
    chk({tag, ".int_req"},  32'(INT_REQ),   32'd0);
    chk({tag, ".err"},      32'(ERR),       32'd0);
  endtask

  initial begin
    CLR_N = 1'b0; IN_DATA = '0; IN_VALID = 1'b0; INP_EXEC = 1'b0;
    OUT_EXEC = 1'b0; AC_LOW = '0; OUT_READY = 1'b0;
    ION = 1'b0; IOF = 1'b0; INT_ACK = 1'b0;

    // Power-up reset
    tick();
    chk_reset_state("por");
    CLR_N = 1'b1;
    tick();

    // Input capture and consumption
    IN_DATA = 8'h41; IN_VALID = 1'b1;
    tick();
    IN_VALID = 1'b0;
    chk("cap.fgi",      32'(FGI),       32'd1);
    chk("cap.inpr",     32'(INPR_DATA), 32'h41);
    chk("cap.in_ready", 32'(IN_READY),  32'd0);

    IN_DATA = 8'h33; IN_VALID = 1'b1;
    tick();
    IN_VALID = 1'b0;
    chk("bp.inpr", 32'(INPR_DATA), 32'h41);
    chk("bp.fgi",  32'(FGI),       32'd1);

    INP_EXEC = 1'b1;
    chk("inp.inpr_during", 32'(INPR_DATA), 32'h41);
    tick();
    INP_EXEC = 1'b0;
    chk("inp.fgi",      32'(FGI),       32'd0);
    chk("inp.inpr",     32'(INPR_DATA), 32'h41);
    chk("inp.in_ready", 32'(IN_READY),  32'd1);
    chk("inp.err",      32'(ERR),       32'd0);

    // Output load, hold, and device take
    AC_LOW = 8'h5A; OUT_EXEC = 1'b1;
    tick();
    OUT_EXEC = 1'b0; AC_LOW = 8'h00;
    chk("out.outr", 32'(OUTR_DATA), 32'h5A);
    chk("out.vld",  32'(OUT_VALID), 32'd1);
    chk("out.fgo",  32'(FGO),       32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold.outr", 32'(OUTR_DATA), 32'h5A);
      chk("hold.vld",  32'(OUT_VALID), 32'd1);
    end
    OUT_READY = 1'b1;
    tick();
    chk("take.fgo",  32'(FGO),       32'd1);
    chk("take.vld",  32'(OUT_VALID), 32'd0);
    chk("take.outr", 32'(OUTR_DATA), 32'h5A);
    tick();
    OUT_READY = 1'b0;
    chk("idle_rdy.fgo",  32'(FGO),       32'd1);
    chk("idle_rdy.outr", 32'(OUTR_DATA), 32'h5A);
    chk("idle_rdy.err",  32'(ERR),       32'd0);

    // Protocol errors
    INP_EXEC = 1'b1;
    tick();
    INP_EXEC = 1'b0;
    chk("err_inp.err",  32'(ERR),       32'd1);
    chk("err_inp.inpr", 32'(INPR_DATA), 32'h41);
    chk("err_inp.fgi",  32'(FGI),       32'd0);

    AC_LOW = 8'h12; OUT_EXEC = 1'b1;
    tick();
    chk("reload.outr", 32'(OUTR_DATA), 32'h12);
    AC_LOW = 8'hFF;
    tick();
    OUT_EXEC = 1'b0;
    chk("err_out.outr", 32'(OUTR_DATA), 32'h12);
    chk("err_out.vld",  32'(OUT_VALID), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("err_sticky", 32'(ERR), 32'd1);
    end

    // Async reset mid-cycle with a character pending on both sides
    IN_DATA = 8'h77; IN_VALID = 1'b1;
    tick();
    IN_VALID = 1'b0;
    chk("pre_rst.fgi", 32'(FGI),       32'd1);
    chk("pre_rst.vld", 32'(OUT_VALID), 32'd1);
    #2;
    CLR_N = 1'b0;
    #1;
    chk_reset_state("async");
    #1;
    CLR_N = 1'b1;
    tick();
    chk_reset_state("post_rst");

`ifdef IO_INTERRUPT_EN
    ION = 1'b1;
    tick();
    ION = 1'b0;
    chk("ion.ien",     32'(IEN),     32'd1);
    chk("ion.int_req", 32'(INT_REQ), 32'd0);
    tick();
    chk("ion.int_req_next", 32'(INT_REQ), 32'd1);
    INT_ACK = 1'b1; ION = 1'b1;
    tick();
    INT_ACK = 1'b0; ION = 1'b0;
    chk("ack.ien",     32'(IEN),     32'd0);
    chk("ack.int_req", 32'(INT_REQ), 32'd0);
    ION = 1'b1; IOF = 1'b1;
    tick();
    ION = 1'b0; IOF = 1'b0;
    chk("iof.ien", 32'(IEN), 32'd0);
`else
    IN_DATA = 8'h20; IN_VALID = 1'b1; ION = 1'b1;
    tick();
    IN_VALID = 1'b0;
    chk("noint.fgi", 32'(FGI), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("noint.ien",     32'(IEN),     32'd0);
      chk("noint.int_req", 32'(INT_REQ), 32'd0);
      tick();
    end
    ION = 1'b0; INT_ACK = 1'b1; IOF = 1'b1;
    tick();
    INT_ACK = 1'b0; IOF = 1'b0;
    chk("noint.ack_ien", 32'(IEN),       32'd0);
    chk("noint.inpr",    32'(INPR_DATA), 32'h20);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
